// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and runs mult/multu/div/divu over a
// fixed number of busy cycles, driving the stall request seen by the hazard logic.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mdu_start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] mdu_A,
  input  logic [31:0] mdu_B,
  output logic        mdu_busy,
  output logic        mdu_stall,
  output logic [31:0] mdu_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CW-1:0] count;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [3:0]    op_q;

  logic               is_arith;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        div_bs;
  logic [31:0]        div_bu;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  assign is_arith = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Dividing 0x80000000 by 1 instead of -1 yields exactly the required
  // LO=0x80000000, HI=0 and keeps the signed divider away from overflow.
  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign div_bs   = (div_zero || div_ovf) ? 32'd1 : b_q;
  assign div_bu   = div_zero ? 32'd1 : b_q;

  assign quo_s = $signed(a_q) / $signed(div_bs);
  assign rem_s = $signed(a_q) % $signed(div_bs);
  assign quo_u = a_q / div_bu;
  assign rem_u = a_q % div_bu;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else if (count != '0) begin
      // A running operation ignores new starts and req; it retires at count==1.
      if (count == CW'(1)) begin
        count <= '0;
        case (op_q)
          OP_MULT:  {HI, LO} <= prod_s;
          OP_MULTU: {HI, LO} <= prod_u;
          OP_DIV: begin
            if (!div_zero) begin
              HI <= rem_s;
              LO <= quo_s;
            end
          end
          OP_DIVU: begin
            if (!div_zero) begin
              HI <= rem_u;
              LO <= quo_u;
            end
          end
          default: ;
        endcase
      end else begin
        count <= count - 1'b1;
      end
    end else if (mdu_start && !req) begin
      case (mdu_op)
        OP_MULT, OP_MULTU: begin
          a_q   <= mdu_A;
          b_q   <= mdu_B;
          op_q  <= mdu_op;
          count <= CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          a_q   <= mdu_A;
          b_q   <= mdu_B;
          op_q  <= mdu_op;
          count <= CW'(DIV_CYCLES);
        end
        OP_MTHI: HI <= mdu_A;
        OP_MTLO: LO <= mdu_A;
        default: ;
      endcase
    end
  end

  assign mdu_busy  = (count != '0);
  assign mdu_stall = mdu_busy | (mdu_start & is_arith & ~req);

  always_comb begin
    mdu_out = 32'd0;
    case (mdu_op)
      OP_MFHI: mdu_out = HI;
      OP_MFLO: mdu_out = LO;
      default: mdu_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: driver pushes expected HI/LO and busy length into a queue,
// a monitor pops and compares each time busy drops.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_A;
  logic [31:0] mdu_B;
  logic        mdu_busy;
  logic        mdu_stall;
  logic [31:0] mdu_out;
  logic [31:0] HI;
  logic [31:0] LO;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .mdu_start(mdu_start), .mdu_op(mdu_op),
    .mdu_A(mdu_A), .mdu_B(mdu_B), .mdu_busy(mdu_busy), .mdu_stall(mdu_stall),
    .mdu_out(mdu_out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry retires per busy period.
  initial begin : monitor
    int   busy_run;
    logic stall_ok;
    exp_t e;
    busy_run = 0;
    stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (mdu_busy === 1'b1) begin
        busy_run++;
        if (mdu_stall !== 1'b1) stall_ok = 1'b0;
      end else if (busy_run > 0) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: busy period of %0d with no expected entry", busy_run);
        end else begin
          e = sb_q.pop_front();
          chk("busy_len", busy_run, e.cyc);
          chk("hi_result", HI, e.hi);
          chk("lo_result", LO, e.lo);
          chk("stall_while_busy", {31'd0, stall_ok}, 32'd1);
        end
        busy_run = 0;
        stall_ok = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model from arithmetic on 64-bit integers.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, rm;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; rm = sa % sb; m_lo = q[31:0]; m_hi = rm[31:0]; end
      4'd4: if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic abort);
    logic arith;
    exp_t e;
    arith = (op >= 4'd1) && (op <= 4'd4);
    if (!r) model(op, a, b);
    if (arith && !r) begin
      e.cyc = (op <= 4'd2) ? 5 : 10;
      e.hi  = m_hi;
      e.lo  = m_lo;
      if (abort) begin
        e.cyc = 3; e.hi = 32'd0; e.lo = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
      end
      sb_q.push_back(e);
    end
    @(negedge clk);
    mdu_start = 1'b1; mdu_op = op; mdu_A = a; mdu_B = b; req = r;
    #1;
    chk("stall_start", {31'd0, mdu_stall}, {31'd0, arith && !r});
    @(posedge clk);
    @(negedge clk);
    mdu_start = 1'b0; mdu_op = 4'd0; req = 1'b0;
    #1;
    chk("busy_after_start", {31'd0, mdu_busy}, {31'd0, arith && !r});
    if (!arith || r) begin
      chk("hi_immediate", HI, m_hi);
      chk("lo_immediate", LO, m_lo);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (mdu_busy === 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", mdu_busy, g);
    end
  endtask

  task automatic rd(input logic [3:0] op, input string nm);
    mdu_op = op;
    #1;
    chk(nm, mdu_out, (op == 4'd7) ? m_hi : m_lo);
    mdu_op = 4'd0;
  endtask

  initial begin : stim
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        r;
    reset = 1'b1; req = 1'b0; mdu_start = 1'b0; mdu_op = 4'd0; mdu_A = '0; mdu_B = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", {31'd0, mdu_busy}, 32'd0);
    chk("reset_stall", {31'd0, mdu_stall}, 32'd0);
    reset = 1'b0;

    drive(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    wait_idle();
    rd(4'd8, "mflo_after_mult");
    rd(4'd7, "mfhi_after_mult");

    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    wait_idle();
    drive(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    wait_idle();
    rd(4'd8, "mflo_after_divu");

    drive(4'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    rd(4'd7, "mfhi_after_mthi");
    drive(4'd4, 32'd99, 32'd0, 1'b0, 1'b0);
    wait_idle();
    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle();

    drive(4'd1, 32'd1000, 32'd1000, 1'b1, 1'b0);
    drive(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);

    // req plus an illegal start while multu runs: neither may disturb it
    drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    req = 1'b1; mdu_start = 1'b1; mdu_op = 4'd3; mdu_A = 32'd5; mdu_B = 32'd7;
    #1;
    chk("stall_busy_req", {31'd0, mdu_stall}, 32'd1);
    @(negedge clk);
    req = 1'b0; mdu_op = 4'd5;
    @(negedge clk);
    mdu_start = 1'b0; mdu_op = 4'd0;
    wait_idle();

    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("busy_after_reset", {31'd0, mdu_busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("hi_no_late_write", HI, 32'd0);
    chk("lo_no_late_write", LO, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      r = ($urandom_range(0, 7) == 0);
      drive(op, a, b, r, 1'b0);
      wait_idle();
      rd(4'd7, "rand_mfhi");
      rd(4'd8, "rand_mflo");
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
